// File: rtl/sync_pkg.sv
// Shared definitions for the frame-sync generator: source select codes and
// quadrature step classification.
package sync_pkg;

    localparam logic [1:0] SYNC_OFF  = 2'd0;
    localparam logic [1:0] SYNC_INT  = 2'd1;
    localparam logic [1:0] SYNC_ENC  = 2'd2;
    localparam logic [1:0] SYNC_TRIG = 2'd3;

    typedef enum logic [1:0] {
        QSTEP_NONE = 2'd0,
        QSTEP_FWD  = 2'd1,
        QSTEP_REV  = 2'd2,
        QSTEP_ERR  = 2'd3
    } quad_step_t;

    // Gray state {a,b} to position: 00->0, 01->1, 11->2, 10->3
    function automatic logic [1:0] quad_pos(input logic [1:0] ab);
        return {ab[1], ab[1] ^ ab[0]};
    endfunction

    function automatic quad_step_t quad_step(input logic [1:0] prev, input logic [1:0] cur);
        logic [1:0] delta;
        delta = quad_pos(cur) - quad_pos(prev);
        case (delta)
            2'd1:    return QSTEP_FWD;
            2'd3:    return QSTEP_REV;
            2'd2:    return QSTEP_ERR;
            default: return QSTEP_NONE;
        endcase
    endfunction

endpackage

// File: rtl/quad_decoder.sv
// Quadrature decoder: two-stage synchronisers, history register and a
// registered step/direction/illegal-transition classification.
module quad_decoder
    import sync_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic ch_a,
    input  logic ch_b,
    output logic step,
    output logic dir,
    output logic err
);

    logic [1:0] pins;
    logic [1:0] sync_vec;
    logic [1:0] hist_reg;
    logic       step_reg;
    logic       dir_reg;
    logic       err_reg;
    quad_step_t step_code;

    assign pins = {ch_a, ch_b};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            logic meta_reg;
            logic sync_reg;
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    meta_reg <= 1'b0;
                    sync_reg <= 1'b0;
                end else begin
                    meta_reg <= pins[gi];
                    sync_reg <= meta_reg;
                end
            end
        end
    endgenerate

    assign sync_vec  = {g_sync[1].sync_reg, g_sync[0].sync_reg};
    assign step_code = quad_step(hist_reg, sync_vec);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hist_reg <= 2'b00;
            step_reg <= 1'b0;
            dir_reg  <= 1'b0;
            err_reg  <= 1'b0;
        end else begin
            hist_reg <= sync_vec;
            step_reg <= (step_code == QSTEP_FWD) || (step_code == QSTEP_REV);
            dir_reg  <= (step_code == QSTEP_FWD);
            err_reg  <= (step_code == QSTEP_ERR);
        end
    end

    assign step = step_reg;
    assign dir  = dir_reg;
    assign err  = err_reg;

endmodule

// File: rtl/sync_generator.sv
// Frame-sync generator: timer/encoder/trigger candidate sources, holdoff and
// pulse gating, sync/drop counters, way meter and microsecond system timer.
module sync_generator
    import sync_pkg::*;
#(
    parameter int CLK_HZ    = 100_000_000,
    parameter int TICK_HZ   = 1_000_000,
    parameter int DIV_W     = 16,
    parameter int HOLD_W    = 16,
    parameter int WAY_W     = 32,
    parameter int PULSE_CYC = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    i_ch_a,
    input  logic                    i_ch_b,
    input  logic                    i_trig,
    input  logic [1:0]              i_mode,
    input  logic                    i_trig_edge,
    input  logic [DIV_W-1:0]        i_int_period,
    input  logic [DIV_W-1:0]        i_enc_step,
    input  logic                    i_enc_bidir,
    input  logic [HOLD_W-1:0]       i_holdoff,
    input  logic                    i_clr_counters,
    output logic                    o_sync,
    output logic                    o_sync_strobe,
    output logic [31:0]             o_sync_counter,
    output logic [15:0]             o_drop_counter,
    output logic signed [WAY_W-1:0] o_way_meter,
    output logic                    o_enc_err,
    output logic [31:0]             o_system_timer
);

    localparam int TICK_DIV = CLK_HZ / TICK_HZ;
    localparam int TICK_W   = $clog2(TICK_DIV);
    localparam int PULSE_W  = $clog2(PULSE_CYC + 1);
    localparam logic [TICK_W-1:0]        TICK_MAX = TICK_W'(TICK_DIV - 1);
    localparam logic signed [DIV_W:0]    ACC_ONE  = 1;

    logic [TICK_W-1:0]      tick_cnt_reg;
    logic                   tick;
    logic [31:0]            timer_reg;

    logic                   trig_meta_reg;
    logic                   trig_sync_reg;
    logic                   trig_hist_reg;
    logic                   trig_edge;

    logic                   q_step;
    logic                   q_dir;
    logic                   q_err;

    logic [1:0]             mode_reg;
    logic                   mode_change;

    logic [DIV_W-1:0]       period_reg;
    logic [DIV_W-1:0]       period_next;
    logic signed [DIV_W:0]  acc_reg;
    logic signed [DIV_W:0]  acc_next;
    logic signed [DIV_W:0]  acc_inc;
    logic signed [DIV_W:0]  acc_dec;
    logic signed [DIV_W:0]  step_pos;
    logic signed [DIV_W:0]  step_neg;
    logic [DIV_W-1:0]       enc_step_eff;
    logic                   cand;

    logic [HOLD_W-1:0]      holdoff_reg;
    logic [PULSE_W-1:0]     pulse_cnt_reg;
    logic                   strobe_reg;
    logic                   accept;
    logic                   reject;

    logic [31:0]            sync_cnt_reg;
    logic [15:0]            drop_cnt_reg;
    logic signed [WAY_W-1:0] way_reg;
    logic                   enc_err_reg;

    assign tick = (tick_cnt_reg == TICK_MAX);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_cnt_reg <= '0;
            timer_reg    <= '0;
        end else begin
            tick_cnt_reg <= tick ? '0 : tick_cnt_reg + TICK_W'(1);
            if (tick) begin
                timer_reg <= timer_reg + 32'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trig_meta_reg <= 1'b0;
            trig_sync_reg <= 1'b0;
            trig_hist_reg <= 1'b0;
        end else begin
            trig_meta_reg <= i_trig;
            trig_sync_reg <= trig_meta_reg;
            trig_hist_reg <= trig_sync_reg;
        end
    end

    assign trig_edge = i_trig_edge ? (~trig_sync_reg & trig_hist_reg)
                                   : (trig_sync_reg & ~trig_hist_reg);

    quad_decoder u_quad_decoder (
        .clk   (clk),
        .rst_n (rst_n),
        .ch_a  (i_ch_a),
        .ch_b  (i_ch_b),
        .step  (q_step),
        .dir   (q_dir),
        .err   (q_err)
    );

    assign mode_change  = (i_mode != mode_reg);
    assign enc_step_eff = (i_enc_step == '0) ? DIV_W'(1) : i_enc_step;
    assign step_pos     = $signed({1'b0, enc_step_eff});
    assign step_neg     = -step_pos;
    assign acc_inc      = acc_reg + ACC_ONE;
    assign acc_dec      = acc_reg - ACC_ONE;

    // Magnitude compares (>=, <=) keep the sources from running away if the
    // period or step is lowered below the current count.
    always_comb begin
        period_next = period_reg;
        acc_next    = acc_reg;
        cand        = 1'b0;
        case (i_mode)
            SYNC_INT: begin
                if (tick) begin
                    if (period_reg >= i_int_period) begin
                        cand        = 1'b1;
                        period_next = '0;
                    end else begin
                        period_next = period_reg + DIV_W'(1);
                    end
                end
            end
            SYNC_ENC: begin
                if (q_step) begin
                    if (q_dir) begin
                        if (acc_inc >= step_pos) begin
                            cand     = 1'b1;
                            acc_next = '0;
                        end else begin
                            acc_next = acc_inc;
                        end
                    end else begin
                        if (acc_dec <= step_neg) begin
                            cand     = i_enc_bidir;
                            acc_next = '0;
                        end else begin
                            acc_next = acc_dec;
                        end
                    end
                end
            end
            SYNC_TRIG: cand = trig_edge;
            default:   cand = 1'b0;
        endcase
        if (mode_change) begin
            period_next = '0;
            acc_next    = '0;
            cand        = 1'b0;
        end
    end

    assign accept = cand && (holdoff_reg == '0) && (pulse_cnt_reg == '0);
    assign reject = cand && !accept;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_reg      <= SYNC_OFF;
            period_reg    <= '0;
            acc_reg       <= '0;
            holdoff_reg   <= '0;
            pulse_cnt_reg <= '0;
            strobe_reg    <= 1'b0;
        end else begin
            mode_reg   <= i_mode;
            period_reg <= period_next;
            acc_reg    <= acc_next;
            strobe_reg <= accept;
            if (accept) begin
                holdoff_reg <= i_holdoff;
            end else if (tick && holdoff_reg != '0) begin
                holdoff_reg <= holdoff_reg - HOLD_W'(1);
            end
            if (accept) begin
                pulse_cnt_reg <= PULSE_W'(PULSE_CYC);
            end else if (pulse_cnt_reg != '0) begin
                pulse_cnt_reg <= pulse_cnt_reg - PULSE_W'(1);
            end
        end
    end

    // Clear wins over any same-cycle increment; the pulse itself is unaffected.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_cnt_reg <= '0;
            drop_cnt_reg <= '0;
            way_reg      <= '0;
            enc_err_reg  <= 1'b0;
        end else if (i_clr_counters) begin
            sync_cnt_reg <= '0;
            drop_cnt_reg <= '0;
            way_reg      <= '0;
            enc_err_reg  <= 1'b0;
        end else begin
            if (accept) begin
                sync_cnt_reg <= sync_cnt_reg + 32'd1;
            end
            if (reject && drop_cnt_reg != 16'hFFFF) begin
                drop_cnt_reg <= drop_cnt_reg + 16'd1;
            end
            if (q_step) begin
                way_reg <= q_dir ? way_reg + WAY_W'(1) : way_reg - WAY_W'(1);
            end
            if (q_err) begin
                enc_err_reg <= 1'b1;
            end
        end
    end

    assign o_sync         = (pulse_cnt_reg != '0);
    assign o_sync_strobe  = strobe_reg;
    assign o_sync_counter = sync_cnt_reg;
    assign o_drop_counter = drop_cnt_reg;
    assign o_way_meter    = way_reg;
    assign o_enc_err      = enc_err_reg;
    assign o_system_timer = timer_reg;

endmodule

// File: tb/tb_sync_generator.sv
// Directed bench for sync_generator; 10 clk per tick so that 1 ms of mode-off
// observation fits a short run, and PULSE_CYC=4 for the mid-pulse reset case.
module tb_sync_generator;
    import sync_pkg::*;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               i_ch_a, i_ch_b, i_trig;
    logic [1:0]         i_mode;
    logic               i_trig_edge;
    logic [15:0]        i_int_period;
    logic [15:0]        i_enc_step;
    logic               i_enc_bidir;
    logic [15:0]        i_holdoff;
    logic               i_clr_counters;
    logic               o_sync, o_sync_strobe, o_enc_err;
    logic [31:0]        o_sync_counter, o_system_timer;
    logic [15:0]        o_drop_counter;
    logic signed [31:0] o_way_meter;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int pos       = 0;
    logic [1:0] gray [4];

    always #5 clk = ~clk;

    sync_generator #(
        .CLK_HZ    (10_000_000),
        .TICK_HZ   (1_000_000),
        .DIV_W     (16),
        .HOLD_W    (16),
        .WAY_W     (32),
        .PULSE_CYC (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_ch_a         (i_ch_a),
        .i_ch_b         (i_ch_b),
        .i_trig         (i_trig),
        .i_mode         (i_mode),
        .i_trig_edge    (i_trig_edge),
        .i_int_period   (i_int_period),
        .i_enc_step     (i_enc_step),
        .i_enc_bidir    (i_enc_bidir),
        .i_holdoff      (i_holdoff),
        .i_clr_counters (i_clr_counters),
        .o_sync         (o_sync),
        .o_sync_strobe  (o_sync_strobe),
        .o_sync_counter (o_sync_counter),
        .o_drop_counter (o_drop_counter),
        .o_way_meter    (o_way_meter),
        .o_enc_err      (o_enc_err),
        .o_system_timer (o_system_timer)
    );

    task automatic set_quad(input int p);
        logic [1:0] v;
        v = gray[p % 4];
        i_ch_a = v[1];
        i_ch_b = v[0];
    endtask

    task automatic enc_move(input bit fwd);
        pos = fwd ? (pos + 1) % 4 : (pos + 3) % 4;
        set_quad(pos);
        repeat (12) @(negedge clk);
    endtask

    task automatic clear_counters;
        @(negedge clk);
        i_clr_counters = 1'b1;
        @(negedge clk);
        i_clr_counters = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        total_cnt++;
        if ({o_sync, o_sync_strobe, o_enc_err} !== 3'b000) $display("FAIL reset_flags: got %b want 000", {o_sync, o_sync_strobe, o_enc_err});
        else pass_cnt++;
        total_cnt++;
        if (o_sync_counter !== 32'd0 || o_drop_counter !== 16'd0) $display("FAIL reset_counters: got sync=%0d drop=%0d want 0/0", o_sync_counter, o_drop_counter);
        else pass_cnt++;
        total_cnt++;
        if (o_way_meter !== 32'sd0 || o_system_timer !== 32'd0) $display("FAIL reset_way_timer: got way=%0d timer=%0d want 0/0", o_way_meter, o_system_timer);
        else pass_cnt++;
        rst_n = 1'b1;
        $display("test_reset done");
    endtask

    task automatic test_internal;
        int strobes, first, second, bad_align;
        strobes = 0; first = -1; second = -1; bad_align = 0;
        @(negedge clk);
        i_int_period = 16'd9; i_holdoff = 16'd0; i_mode = SYNC_INT; i_clr_counters = 1'b1;
        @(negedge clk);
        i_clr_counters = 1'b0;
        for (int k = 1; k <= 540; k++) begin
            @(negedge clk);
            if (o_sync_strobe) begin
                strobes++;
                if (!o_sync) bad_align++;
                if (first < 0) first = k;
                else if (second < 0) second = k;
            end
        end
        total_cnt++;
        if (strobes != 5) $display("FAIL int_strobes: got %0d want 5", strobes); else pass_cnt++;
        total_cnt++;
        if (o_sync_counter !== 32'd5) $display("FAIL int_counter: got %0d want 5", o_sync_counter); else pass_cnt++;
        total_cnt++;
        if (o_drop_counter !== 16'd0) $display("FAIL int_drop: got %0d want 0", o_drop_counter); else pass_cnt++;
        total_cnt++;
        if (second - first != 100) $display("FAIL int_period: got %0d clk want 100", second - first); else pass_cnt++;
        total_cnt++;
        if (bad_align != 0) $display("FAIL int_strobe_sync_align: got %0d misaligned want 0", bad_align); else pass_cnt++;
        $display("test_internal done: strobes=%0d interval=%0d", strobes, second - first);
    endtask

    task automatic test_encoder;
        @(negedge clk);
        i_mode = SYNC_ENC; i_enc_step = 16'd4; i_enc_bidir = 1'b0;
        clear_counters();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < 12; i++) enc_move(1'b1);
            total_cnt++;
            if (o_sync_counter !== 32'd3) $display("FAIL enc_fwd_syncs_r%0d: got %0d want 3", r, o_sync_counter); else pass_cnt++;
            for (int i = 0; i < 8; i++) enc_move(1'b0);
            total_cnt++;
            if (o_sync_counter !== (r == 0 ? 32'd3 : 32'd5)) $display("FAIL enc_total_syncs_r%0d: got %0d want %0d", r, o_sync_counter, (r == 0 ? 3 : 5));
            else pass_cnt++;
            total_cnt++;
            if (o_way_meter !== 32'sd4) $display("FAIL enc_way_r%0d: got %0d want 4", r, o_way_meter); else pass_cnt++;
            total_cnt++;
            if (o_drop_counter !== 16'd0) $display("FAIL enc_drop_r%0d: got %0d want 0", r, o_drop_counter); else pass_cnt++;
            clear_counters();
            i_enc_bidir = 1'b1;
        end
        i_enc_step = 16'd0;
        for (int i = 0; i < 4; i++) enc_move(1'b1);
        total_cnt++;
        if (o_sync_counter !== 32'd4) $display("FAIL enc_step_zero: got %0d want 4", o_sync_counter); else pass_cnt++;
        $display("test_encoder done: way=%0d", o_way_meter);
    endtask

    task automatic test_enc_error;
        @(negedge clk);
        i_mode = SYNC_OFF;
        clear_counters();
        i_ch_a = 1'b1; i_ch_b = 1'b1;
        repeat (12) @(negedge clk);
        total_cnt++;
        if (o_enc_err !== 1'b1 || o_way_meter !== 32'sd0) $display("FAIL enc_illegal: got err=%b way=%0d want 1/0", o_enc_err, o_way_meter);
        else pass_cnt++;
        i_ch_a = 1'b1; i_ch_b = 1'b0;
        repeat (12) @(negedge clk);
        i_ch_a = 1'b0; i_ch_b = 1'b0;
        repeat (12) @(negedge clk);
        pos = 0;
        total_cnt++;
        if (o_enc_err !== 1'b1 || o_way_meter !== 32'sd2) $display("FAIL enc_err_sticky: got err=%b way=%0d want 1/2", o_enc_err, o_way_meter);
        else pass_cnt++;
        clear_counters();
        @(negedge clk);
        total_cnt++;
        if (o_enc_err !== 1'b0 || o_way_meter !== 32'sd0) $display("FAIL enc_err_clear: got err=%b way=%0d want 0/0", o_enc_err, o_way_meter);
        else pass_cnt++;
        $display("test_enc_error done");
    endtask

    task automatic test_trigger;
        @(negedge clk);
        i_mode = SYNC_TRIG; i_trig_edge = 1'b0; i_holdoff = 16'd100; i_trig = 1'b0;
        clear_counters();
        for (int i = 0; i < 8; i++) begin
            i_trig = 1'b1;
            repeat (50) @(negedge clk);
            i_trig = 1'b0;
            repeat (250) @(negedge clk);
        end
        total_cnt++;
        if (o_sync_counter !== 32'd2) $display("FAIL trig_accepted: got %0d want 2", o_sync_counter); else pass_cnt++;
        total_cnt++;
        if (o_drop_counter !== 16'd6) $display("FAIL trig_dropped: got %0d want 6", o_drop_counter); else pass_cnt++;
        i_holdoff = 16'd0; i_trig_edge = 1'b1; i_trig = 1'b1;
        repeat (20) @(negedge clk);
        total_cnt++;
        if (o_sync_counter !== 32'd2) $display("FAIL trig_fall_ignores_rise: got %0d want 2", o_sync_counter); else pass_cnt++;
        i_trig = 1'b0;
        repeat (20) @(negedge clk);
        total_cnt++;
        if (o_sync_counter !== 32'd3 || o_drop_counter !== 16'd6) $display("FAIL trig_fall_edge: got sync=%0d drop=%0d want 3/6", o_sync_counter, o_drop_counter);
        else pass_cnt++;
        $display("test_trigger done");
    endtask

    task automatic test_clear_same_cycle;
        int strobes, high_cycles;
        strobes = 0; high_cycles = 0;
        i_trig_edge = 1'b0;
        repeat (5) @(negedge clk);
        i_trig = 1'b1;
        @(negedge clk);
        @(negedge clk);
        i_clr_counters = 1'b1;
        @(negedge clk);
        i_clr_counters = 1'b0;
        total_cnt++;
        if (o_sync_strobe !== 1'b1 || o_sync !== 1'b1) $display("FAIL clr_pulse_emitted: got strobe=%b sync=%b want 1/1", o_sync_strobe, o_sync);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (o_sync_counter !== 32'd0) $display("FAIL clr_priority: got %0d want 0", o_sync_counter); else pass_cnt++;
        repeat (10) @(negedge clk);
        i_trig = 1'b0;
        i_mode = SYNC_OFF;
        clear_counters();
        for (int k = 0; k < 10000; k++) begin
            @(negedge clk);
            if (k % 500 == 0) i_trig = ~i_trig;
            if (o_sync_strobe) strobes++;
            if (o_sync) high_cycles++;
        end
        total_cnt++;
        if (strobes != 0 || high_cycles != 0) $display("FAIL off_no_sync: got strobes=%0d high=%0d want 0/0", strobes, high_cycles);
        else pass_cnt++;
        total_cnt++;
        if (o_sync_counter !== 32'd0 || o_drop_counter !== 16'd0) $display("FAIL off_counters: got sync=%0d drop=%0d want 0/0", o_sync_counter, o_drop_counter);
        else pass_cnt++;
        i_trig = 1'b0;
        $display("test_clear_same_cycle done");
    endtask

    task automatic test_reset_mid_pulse;
        bit found;
        int first, timer_at;
        found = 1'b0; first = -1; timer_at = -1;
        @(negedge clk);
        i_mode = SYNC_INT; i_int_period = 16'd9; i_holdoff = 16'd0;
        for (int k = 0; k < 300 && !found; k++) begin
            @(negedge clk);
            if (o_sync_strobe) found = 1'b1;
        end
        total_cnt++;
        if (!found) $display("FAIL rst_wait_sync: got no strobe in 300 clk want strobe");
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (o_sync !== 1'b1) $display("FAIL rst_pulse_len: got sync=%b want 1", o_sync); else pass_cnt++;
        #2 rst_n = 1'b0;
        #1;
        total_cnt++;
        if (o_sync !== 1'b0 || o_sync_strobe !== 1'b0) $display("FAIL rst_drops_sync: got sync=%b strobe=%b want 0/0", o_sync, o_sync_strobe);
        else pass_cnt++;
        total_cnt++;
        if (o_sync_counter !== 32'd0 || o_system_timer !== 32'd0 || o_drop_counter !== 16'd0)
            $display("FAIL rst_counters: got sync=%0d timer=%0d drop=%0d want 0/0/0", o_sync_counter, o_system_timer, o_drop_counter);
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 1; k <= 150; k++) begin
            @(negedge clk);
            if (o_sync_strobe && first < 0) first = k;
            if (k == 100) timer_at = int'(o_system_timer);
        end
        total_cnt++;
        if (first < 99 || first > 101) $display("FAIL rst_first_sync: got clk %0d want 100", first); else pass_cnt++;
        total_cnt++;
        if (timer_at != 10) $display("FAIL rst_timer: got %0d want 10", timer_at); else pass_cnt++;
        $display("test_reset_mid_pulse done: first sync at clk %0d", first);
    endtask

    initial begin
        gray[0] = 2'b00; gray[1] = 2'b01; gray[2] = 2'b11; gray[3] = 2'b10;
        rst_n = 1'b0;
        i_ch_a = 1'b0; i_ch_b = 1'b0; i_trig = 1'b0;
        i_mode = SYNC_OFF; i_trig_edge = 1'b0;
        i_int_period = 16'd0; i_enc_step = 16'd0; i_enc_bidir = 1'b0;
        i_holdoff = 16'd0; i_clr_counters = 1'b0;
        test_reset();
        test_internal();
        test_encoder();
        test_enc_error();
        test_trigger();
        test_clear_same_cycle();
        test_reset_mid_pulse();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
